regfile_write_arbiter: RTL and testbench

//  Shares the single register-file write port between two write-back requesters: ALU and load unit.

---
 rtl/regfile_write_arbiter.sv | 158 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and load
// write-back paths, with a registered write stage and a pending-write scoreboard.
module regfile_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [ADDR_W-1:0]   alu_addr,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0]   ld_data,
  input  logic                claim_en,
  input  logic [ADDR_W-1:0]   claim_addr,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data
);

  typedef enum logic [0:0] {
    LAST_ALU = 1'b0,
    LAST_LD  = 1'b1
  } rr_state_e;

  rr_state_e             state_r;
  rr_state_e             state_next_s;
  logic                  grant_alu_s;
  logic                  grant_ld_s;
  logic                  xfer_s;
  logic [ADDR_W-1:0]     xfer_addr_s;
  logic [DATA_W-1:0]     xfer_data_s;
  logic [NUM_REGS-1:0]   busy_r;
  logic [NUM_REGS-1:0]   busy_next_s;

  // Grant decision; gated by rst_n so ready stays low while reset is asserted.
  always_comb begin
    grant_alu_s = 1'b0;
    grant_ld_s  = 1'b0;
    if (!rst_n || stall) begin
      grant_alu_s = 1'b0;
      grant_ld_s  = 1'b0;
    end else if (alu_valid && ld_valid) begin
      if (state_r == LAST_LD) begin
        grant_alu_s = 1'b1;
      end else begin
        grant_ld_s = 1'b1;
      end
    end else if (alu_valid) begin
      grant_alu_s = 1'b1;
    end else if (ld_valid) begin
      grant_ld_s = 1'b1;
    end else begin
      grant_alu_s = 1'b0;
      grant_ld_s  = 1'b0;
    end
  end

  assign alu_ready = grant_alu_s;
  assign ld_ready  = grant_ld_s;
  assign xfer_s    = grant_alu_s | grant_ld_s;

  // Select the address/data of whichever requester is being accepted.
  always_comb begin
    xfer_addr_s = {ADDR_W{1'b0}};
    xfer_data_s = {DATA_W{1'b0}};
    if (grant_alu_s) begin
      xfer_addr_s = alu_addr;
      xfer_data_s = alu_data;
    end else if (grant_ld_s) begin
      xfer_addr_s = ld_addr;
      xfer_data_s = ld_data;
    end else begin
      xfer_addr_s = {ADDR_W{1'b0}};
      xfer_data_s = {DATA_W{1'b0}};
    end
  end

  // Round-robin next state: remember who was granted last, hold otherwise.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      LAST_ALU: begin
        if (grant_ld_s) begin
          state_next_s = LAST_LD;
        end else begin
          state_next_s = LAST_ALU;
        end
      end
      LAST_LD: begin
        if (grant_alu_s) begin
          state_next_s = LAST_ALU;
        end else begin
          state_next_s = LAST_LD;
        end
      end
      default: state_next_s = LAST_LD;
    endcase
  end

  // Round-robin state register; reset favours the ALU on first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= LAST_LD;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Write stage: x0 writes are accepted but never enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= {ADDR_W{1'b0}};
      wr_data <= {DATA_W{1'b0}};
    end else if (xfer_s) begin
      wr_en   <= (xfer_addr_s != {ADDR_W{1'b0}});
      wr_addr <= xfer_addr_s;
      wr_data <= xfer_data_s;
    end else begin
      wr_en <= 1'b0;
    end
  end

  // Scoreboard update: clear first, then set, so a same-address claim wins.
  always_comb begin
    busy_next_s = busy_r;
    if (xfer_s) begin
      busy_next_s[xfer_addr_s] = 1'b0;
    end else begin
      busy_next_s = busy_r;
    end
    if (claim_en) begin
      busy_next_s[claim_addr] = 1'b1;
    end else begin
      busy_next_s[0] = busy_next_s[0];
    end
    busy_next_s[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  assign busy_vec = busy_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a spec-level reference model checked every
// negedge, plus hand-computed literal expectations for each scenario.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_addr = 5'd0;
  logic [31:0] alu_data = 32'd0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_addr = 5'd0;
  logic [31:0] ld_data = 32'd0;
  logic        claim_en = 1'b0;
  logic [4:0]  claim_addr = 5'd0;
  logic [31:0] busy_vec;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int n_checks = 0;
  int n_fail = 0;
  logic chk_on = 1'b0;

  regfile_write_arbiter dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy_vec(busy_vec),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference model: who must be accepted now, and what the write port / scoreboard hold.
  logic        m_alu_last = 1'b0;
  logic        m_wr_en = 1'b0;
  logic [4:0]  m_wr_addr = 5'd0;
  logic [31:0] m_wr_data = 32'd0;
  logic [31:0] m_busy = 32'd0;
  logic [1:0]  eg;

  assign eg = (!rst_n || stall) ? 2'b00 :
              (alu_valid && ld_valid) ? (m_alu_last ? 2'b01 : 2'b10) :
              {alu_valid, ld_valid};

  function automatic logic [31:0] next_busy();
    logic [31:0] b;
    b = m_busy;
    if (eg[1]) b[alu_addr] = 1'b0;
    else if (eg[0]) b[ld_addr] = 1'b0;
    if (claim_en && claim_addr != 5'd0) b[claim_addr] = 1'b1;
    return b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_alu_last <= 1'b0;
      m_wr_en    <= 1'b0;
      m_wr_addr  <= 5'd0;
      m_wr_data  <= 32'd0;
      m_busy     <= 32'd0;
    end else begin
      m_busy <= next_busy();
      if (eg == 2'b10) begin
        m_wr_en    <= (alu_addr != 5'd0);
        m_wr_addr  <= alu_addr;
        m_wr_data  <= alu_data;
        m_alu_last <= 1'b1;
      end else if (eg == 2'b01) begin
        m_wr_en    <= (ld_addr != 5'd0);
        m_wr_addr  <= ld_addr;
        m_wr_data  <= ld_data;
        m_alu_last <= 1'b0;
      end else begin
        m_wr_en <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_alu_ready", 32'(alu_ready), 32'(eg[1]));
      check("cyc_ld_ready", 32'(ld_ready), 32'(eg[0]));
      check("cyc_wr_en", 32'(wr_en), 32'(m_wr_en));
      check("cyc_wr_addr", 32'(wr_addr), 32'(m_wr_addr));
      check("cyc_wr_data", wr_data, m_wr_data);
      check("cyc_busy_vec", busy_vec, m_busy);
    end
  end

  logic [5:0] order;
  int a_cnt, l_cnt, pulses;

  initial begin
    // Reset state, with a valid request present to show ready is held low.
    alu_valid = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_alu_ready", 32'(alu_ready), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_busy", busy_vec, 32'd0);
    alu_valid = 1'b0;
    rst_n = 1'b1;
    chk_on = 1'b1;
    step();

    // 1: single ALU write to r5
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    #1 check("t1_alu_ready", 32'(alu_ready), 32'd1);
    check("t1_ld_ready", 32'(ld_ready), 32'd0);
    step();
    alu_valid = 1'b0;
    check("t1_wr_en", 32'(wr_en), 32'd1);
    check("t1_wr_addr", 32'(wr_addr), 32'd5);
    check("t1_wr_data", wr_data, 32'hDEADBEEF);
    step();
    check("t1_wr_en_drop", 32'(wr_en), 32'd0);

    // 3: load write to x0 is accepted but suppressed
    ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 32'h00001234;
    #1 check("t3_ld_ready", 32'(ld_ready), 32'd1);
    step();
    ld_valid = 1'b0;
    check("t3_wr_en", 32'(wr_en), 32'd0);
    check("t3_wr_data", wr_data, 32'h00001234);
    check("t3_busy", busy_vec, 32'd0);

    // 2: both valid for three writes each, alternating grants
    a_cnt = 0; l_cnt = 0; pulses = 0; order = 6'd0;
    for (int i = 0; i < 6; i++) begin
      alu_valid = (a_cnt < 3); alu_addr = 5'(10 + a_cnt); alu_data = 32'hA000 + 32'(a_cnt);
      ld_valid  = (l_cnt < 3); ld_addr  = 5'(20 + l_cnt); ld_data  = 32'hB000 + 32'(l_cnt);
      #1;
      check("t2_one_ready", 32'(alu_ready & ld_ready), 32'd0);
      order[i] = alu_ready;
      if (alu_ready) a_cnt++;
      else if (ld_ready) l_cnt++;
      if (i > 0) pulses += 32'(wr_en);
      step();
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    pulses += 32'(wr_en);
    check("t2_order", 32'(order), 32'h15);
    check("t2_pulses", 32'(pulses), 32'd6);

    // 4: scoreboard set/clear interactions on r7
    claim_en = 1'b1; claim_addr = 5'd7;
    step();
    claim_en = 1'b0;
    check("t4_claim", 32'(busy_vec[7]), 32'd1);
    ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 32'h77;
    step();
    ld_valid = 1'b0;
    check("t4_clr_wr_en", 32'(wr_en), 32'd1);
    check("t4_clr", 32'(busy_vec[7]), 32'd0);
    claim_en = 1'b1; claim_addr = 5'd7;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h55;
    step();
    claim_en = 1'b0; alu_valid = 1'b0;
    check("t4_set_wins", 32'(busy_vec[7]), 32'd1);
    check("t4_set_wr_en", 32'(wr_en), 32'd1);
    claim_en = 1'b1; claim_addr = 5'd9;
    ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 32'h99;
    step();
    claim_en = 1'b0; ld_valid = 1'b0;
    check("t4_both_busy", busy_vec, 32'h00000200);
    step();

    // 5: stall blocks grants; release resumes round-robin (last was LD)
    stall = 1'b1;
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h33;
    ld_valid  = 1'b1; ld_addr  = 5'd4; ld_data  = 32'h44;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_alu_ready", 32'(alu_ready), 32'd0);
      check("t5_ld_ready", 32'(ld_ready), 32'd0);
      step();
      check("t5_wr_en", 32'(wr_en), 32'd0);
    end
    stall = 1'b0;
    #1 check("t5_rel_alu", 32'(alu_ready), 32'd1);
    check("t5_rel_ld", 32'(ld_ready), 32'd0);
    step();
    alu_valid = 1'b0;
    #1 check("t5_ld_next", 32'(ld_ready), 32'd1);
    step();
    ld_valid = 1'b0;

    // 6: asynchronous reset in the middle of back-to-back writes
    claim_en = 1'b1; claim_addr = 5'd12;
    alu_valid = 1'b1; alu_addr = 5'd13; alu_data = 32'h1313;
    ld_valid  = 1'b1; ld_addr  = 5'd14; ld_data  = 32'h1414;
    step();
    claim_en = 1'b0;
    step();
    check("t6_pre_wr_en", 32'(wr_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_wr_en", 32'(wr_en), 32'd0);
    check("t6_busy", busy_vec, 32'd0);
    check("t6_alu_ready", 32'(alu_ready), 32'd0);
    check("t6_ld_ready", 32'(ld_ready), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1 check("t6_first_alu", 32'(alu_ready), 32'd1);
    check("t6_first_ld", 32'(ld_ready), 32'd0);
    step();
    alu_valid = 1'b0; ld_valid = 1'b0;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
